// File: rtl/reel_spin_if.sv
// Handshake bundle between the game logic / clock_divider and one reel controller.
// REEL_TARGET_EN adds the target symbol input chosen by game logic.
interface reel_spin_if;
  logic        start;
  logic        stop;
  logic        tick;
`ifdef REEL_TARGET_EN
  logic [3:0]  target;
`endif
  logic [25:0] speed;
  logic        div_restart;
  logic [3:0]  symbol;
  logic        spinning;
  logic        done;
  logic [1:0]  dbg_state;

  // start/stop are single-cycle requests; there is no ready: the controller
  // samples them every clock and silently drops requests its state ignores.
  modport master (
`ifdef REEL_TARGET_EN
    output target,
`endif
    output start, stop, tick,
    input  speed, div_restart, symbol, spinning, done, dbg_state
  );

  modport slave (
`ifdef REEL_TARGET_EN
    input  target,
`endif
    input  start, stop, tick,
    output speed, div_restart, symbol, spinning, done, dbg_state
  );
endinterface

// File: rtl/reel_spin_ctrl.sv
// Per-reel start/spin/slowdown sequencer; steps the symbol on each rising tick.
// Optional macro REEL_TARGET_EN holds the final stop until the symbol matches target.
module reel_spin_ctrl #(
  parameter int NUM_SYMBOLS = 10,
  parameter int SPEED_MAX   = 20,
  parameter int SPEED_MIN   = 2,
  parameter int RAMP_TICKS  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  reel_spin_if.slave  bus
);
  localparam int RW = $clog2(RAMP_TICKS + 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_TICKS - 1);
  localparam logic [RW-1:0] RAMP_ONE  = RW'(1);
  localparam logic [3:0]    SYM_LAST  = 4'(NUM_SYMBOLS - 1);
  localparam logic [25:0]   SPD_MAX   = 26'(SPEED_MAX);
  localparam logic [25:0]   SPD_MIN   = 26'(SPEED_MIN);

  typedef enum logic [1:0] {IDLE = 2'd0, SPIN = 2'd1, SLOW = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [25:0]   speed_q, speed_d;
  logic [3:0]    symbol_q, symbol_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic          spinning_q, spinning_d;
  logic          done_q, done_d;
  logic          restart_q, restart_d;
  logic          tick_q;
  logic          step;
  logic [3:0]    sym_next;
  logic          may_finish;

  assign step     = bus.tick & ~tick_q;
  assign sym_next = (symbol_q == SYM_LAST) ? 4'd0 : symbol_q + 4'd1;

`ifdef REEL_TARGET_EN
  assign may_finish = (sym_next == bus.target);
`else
  assign may_finish = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    symbol_d   = symbol_q;
    ramp_d     = ramp_q;
    spinning_d = spinning_q;
    done_d     = 1'b0;
    restart_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = SPIN;
          speed_d    = SPD_MAX;
          spinning_d = 1'b1;
          restart_d  = 1'b1;
          ramp_d     = '0;
        end
      end
      SPIN: begin
        if (step) symbol_d = sym_next;
        // A step coinciding with stop is consumed here, not counted in SLOW.
        if (bus.stop) begin
          state_d = SLOW;
          ramp_d  = '0;
        end
      end
      SLOW: begin
        if (step) begin
          symbol_d = sym_next;
          if (ramp_q != RAMP_LAST) begin
            ramp_d = ramp_q + RAMP_ONE;
          end else if (speed_q > SPD_MIN) begin
            ramp_d  = '0;
            speed_d = speed_q - 26'd1;
          end else if (may_finish) begin
            ramp_d     = '0;
            state_d    = IDLE;
            spinning_d = 1'b0;
            done_d     = 1'b1;
          end
          // Without a target match ramp stays at its last value so every later step re-tests.
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      speed_q    <= SPD_MIN;
      symbol_q   <= 4'd0;
      ramp_q     <= '0;
      spinning_q <= 1'b0;
      done_q     <= 1'b0;
      restart_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      speed_q    <= speed_d;
      symbol_q   <= symbol_d;
      ramp_q     <= ramp_d;
      spinning_q <= spinning_d;
      done_q     <= done_d;
      restart_q  <= restart_d;
      tick_q     <= bus.tick;
    end
  end

  assign bus.speed       = speed_q;
  assign bus.symbol      = symbol_q;
  assign bus.spinning    = spinning_q;
  assign bus.done        = done_q;
  assign bus.div_restart = restart_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_reel_spin_ctrl.sv
// Directed bench for reel_spin_ctrl: vector table plus reset and target sequences.
module tb_reel_spin_ctrl;
  localparam int NS = 10, SMAX = 5, SMIN = 2, RT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reel_spin_if bus();

  reel_spin_ctrl #(
    .NUM_SYMBOLS(NS), .SPEED_MAX(SMAX), .SPEED_MIN(SMIN), .RAMP_TICKS(RT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        start;
    logic        stop;
    logic        step;
    logic [3:0]  target;
    logic [25:0] speed;
    logic [3:0]  sym;
    logic        spin;
    logic        done;
    logic        dr;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic st, logic sp, logic stp, logic [3:0] tg,
                              int spd, int sym, logic spin, logic done, logic dr);
    vec_t v;
    v.start = st; v.stop = sp; v.step = stp; v.target = tg;
    v.speed = 26'(spd); v.sym = 4'(sym); v.spin = spin; v.done = done; v.dr = dr;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag, int spd, int sym, logic spin, logic done, logic dr);
    check({tag, ".speed"},       32'(bus.speed),       32'(spd));
    check({tag, ".symbol"},      32'(bus.symbol),      32'(sym));
    check({tag, ".spinning"},    32'(bus.spinning),    32'(spin));
    check({tag, ".done"},        32'(bus.done),        32'(done));
    check({tag, ".div_restart"}, 32'(bus.div_restart), 32'(dr));
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic st, logic sp, logic stp);
    bus.start = st; bus.stop = sp; bus.tick = stp;
  endtask

  // One step = tick high for one cycle, then low for one cycle.
  task automatic step_once();
    drive(1'b0, 1'b0, 1'b1);
    clk_cycle();
    drive(1'b0, 1'b0, 1'b0);
    clk_cycle();
  endtask

  // Slowdown after stop: k = SLOW steps so far (1..).
  function automatic int slow_speed(int k);
    int s;
    s = SMAX - k / RT;
    return (s < SMIN) ? SMIN : s;
  endfunction

  initial begin
    drive(1'b0, 1'b0, 1'b0);
`ifdef REEL_TARGET_EN
    bus.target = 4'd1;
`endif
    // Reset at power-up.
    rst_n = 1'b0;
    clk_cycle();
    clk_cycle();
    check_outs("por", SMIN, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Table: start, repeated start, 13 steps, stop, 8 slow steps, idle steps.
    vecs.push_back(mk(1, 0, 0, 1, SMAX, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, SMAX, 0, 1, 0, 0));
    for (int k = 1; k <= 13; k++) vecs.push_back(mk(0, 0, 1, 1, SMAX, k % NS, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, SMAX, 3, 1, 0, 0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 0, 1, 1, slow_speed(k), (3 + k) % NS, k < 8, k == 8, 0));
    vecs.push_back(mk(0, 0, 1, 1, SMIN, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, SMIN, 1, 0, 0, 0));
    // start+stop in IDLE goes to SPIN; stop with a step advances the symbol.
    vecs.push_back(mk(1, 1, 0, 0, SMAX, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, SMAX, 2, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, SMAX, 2, 1, 0, 0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 0, 1, 0, slow_speed(k), (2 + k) % NS, k < 8, k == 8, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].step);
`ifdef REEL_TARGET_EN
      bus.target = vecs[i].target;
`endif
      clk_cycle();
      check_outs($sformatf("v%0d", i), int'(vecs[i].speed), int'(vecs[i].sym),
                 vecs[i].spin, vecs[i].done, vecs[i].dr);
      drive(1'b0, 1'b0, 1'b0);
      if (vecs[i].step) begin
        clk_cycle();
        check_outs($sformatf("v%0d_low", i), int'(vecs[i].speed), int'(vecs[i].sym),
                   vecs[i].spin, 1'b0, 1'b0);
      end
    end

    // Reset held two cycles mid-spin, with a tick edge arriving during reset.
    drive(1'b1, 1'b0, 1'b0);
    clk_cycle();
    drive(1'b0, 1'b0, 1'b0);
    step_once();
    step_once();
    check_outs("pre_rst", SMAX, 2, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    clk_cycle();
    clk_cycle();
    check_outs("mid_rst", SMIN, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    step_once();
    check_outs("post_rst", SMIN, 0, 1'b0, 1'b0, 1'b0);

`ifdef REEL_TARGET_EN
    // target=4, stop at symbol 3: ramp ends at 1, done on the step writing 4.
    bus.target = 4'd4;
    drive(1'b1, 1'b0, 1'b0);
    clk_cycle();
    for (int k = 0; k < 3; k++) step_once();
    drive(1'b0, 1'b1, 1'b0);
    clk_cycle();
    drive(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step_once();
    check_outs("tgt_ramp_end", SMIN, 1, 1'b1, 1'b0, 1'b0);
    step_once();
    step_once();
    check_outs("tgt_extra2", SMIN, 3, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    clk_cycle();
    check_outs("tgt_done", SMIN, 4, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    clk_cycle();
    // Unreachable target: reel must keep stepping at SPEED_MIN.
    bus.target = 4'd15;
    drive(1'b1, 1'b0, 1'b0);
    clk_cycle();
    drive(1'b0, 1'b1, 1'b0);
    clk_cycle();
    drive(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8 + 12; k++) step_once();
    check_outs("tgt_never", SMIN, (4 + 20) % NS, 1'b1, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
